mem_access_stage: RTL and testbench

Pipeline memory stage that sits directly upstream of the write-back stage in the vector processor. Takes an executed instruction and its operands: a scalar result/address (21 bits) and a vector (192 bits = 8 lanes × 24 bits). It performs scalar or vector loads/stores against a 24-bit-wide synchronous data memory, serialising one lane per cycle. It then presents registered memData, regE, regV, wb, dest and destType to write-back with a one-cycle out_valid strobe.

---
 rtl/vproc_pkg.sv | 19 +
 rtl/vmem_addr_gen.sv | 75 +++++++
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-processor types and sizes for the memory stage.
package vproc_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned ELEM_W = 24;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t IDLE  = 2'd0;
    localparam mem_state_t ISSUE = 2'd1;
    localparam mem_state_t DRAIN = 2'd2;

endpackage

// File: rtl/vmem_addr_gen.sv
// Element counter and address generator for serialised memory accesses.
// With MEM_STRIDE_EN defined the element address is base + k*stride, else base + k.
module vmem_addr_gen
    import vproc_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned KW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [KW-1:0]     last_idx_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [KW-1:0]     k_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     last_idx_q, last_idx_d;
    logic [ADDR_W-1:0] step;

`ifdef MEM_STRIDE_EN
    logic [ADDR_W-1:0] stride_q, stride_d;

    always_comb begin
        stride_d = start_i ? stride_i : stride_q;
    end

    always_ff @(posedge clk) begin
        if (rst) stride_q <= '0;
        else     stride_q <= stride_d;
    end

    // Product truncates to ADDR_W, so stride 0 broadcasts the base address.
    assign step = ADDR_W'(k_q) * stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^stride_i;
    assign step          = ADDR_W'(k_q);
`endif

    assign last_o = (k_q == last_idx_q);
    assign addr_o = base_q + step;
    assign k_o    = k_q;

    always_comb begin
        base_d     = base_q;
        k_d        = k_q;
        last_idx_d = last_idx_q;
        if (start_i) begin
            base_d     = base_i;
            k_d        = '0;
            last_idx_d = last_idx_i;
        end else if (advance_i && !last_o) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            k_q        <= '0;
            last_idx_q <= '0;
        end else begin
            base_q     <= base_d;
            k_q        <= k_d;
            last_idx_q <= last_idx_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Vector processor memory stage: serialises scalar/vector loads and stores one lane per cycle.
// Optional MEM_STRIDE_EN enables strided element addressing inside vmem_addr_gen.
module mem_access_stage
    import vproc_pkg::*;
#(
    parameter int unsigned LANES  = vproc_pkg::LANES,
    parameter int unsigned ELEM_W = vproc_pkg::ELEM_W,
    parameter int unsigned ADDR_W = 21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                memOp,
    input  logic                      destType,
    input  logic [3:0]                dest,
    input  logic [1:0]                wb,
    input  logic [ADDR_W-1:0]         regE,
    input  logic [LANES*ELEM_W-1:0]   regV,
    input  logic [ADDR_W-1:0]         stride,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [ELEM_W-1:0]         mem_wdata,
    input  logic [ELEM_W-1:0]         mem_rdata,
    output logic                      out_valid,
    output logic [LANES*ELEM_W-1:0]   memData_o,
    output logic [ADDR_W-1:0]         regE_o,
    output logic [LANES*ELEM_W-1:0]   regV_o,
    output logic [1:0]                wb_o,
    output logic [3:0]                dest_o,
    output logic                      destType_o
);

    localparam int unsigned KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VW = LANES * ELEM_W;

    mem_state_t        state_q, state_d;
    logic              is_load_q, is_load_d;
    logic              dt_q, dt_d;
    logic [3:0]        dest_q, dest_d;
    logic [1:0]        wb_q, wb_d;
    logic [ADDR_W-1:0] reg_e_q, reg_e_d;
    logic [VW-1:0]     reg_v_q, reg_v_d;
    logic [VW-1:0]     acc_q, acc_d;
    logic [ELEM_W-1:0] wdata_q, wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic [KW-1:0]     rd_idx_q, rd_idx_d;

    logic              out_valid_q, out_valid_d;
    logic [VW-1:0]     mem_data_out_q, mem_data_out_d;
    logic [ADDR_W-1:0] reg_e_out_q, reg_e_out_d;
    logic [VW-1:0]     reg_v_out_q, reg_v_out_d;
    logic [1:0]        wb_out_q, wb_out_d;
    logic [3:0]        dest_out_q, dest_out_d;
    logic              dt_out_q, dt_out_d;

    mem_op_t       op;
    logic          accept, gen_start, finish, last;
    logic [KW-1:0] k, last_idx;

    assign op        = mem_op_t'(memOp);
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign gen_start = accept && ((op == MEM_LOAD) || (op == MEM_STORE));
    assign last_idx  = destType ? KW'(LANES - 1) : '0;

    vmem_addr_gen #(
        .ADDR_W (ADDR_W),
        .KW     (KW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start_i    (gen_start),
        .advance_i  (state_q == ISSUE),
        .base_i     (regE),
        .stride_i   (stride),
        .last_idx_i (last_idx),
        .addr_o     (mem_addr),
        .k_o        (k),
        .last_o     (last)
    );

    assign mem_we    = (state_q == ISSUE) && !is_load_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d        = state_q;
        is_load_d      = is_load_q;
        dt_d           = dt_q;
        dest_d         = dest_q;
        wb_d           = wb_q;
        reg_e_d        = reg_e_q;
        reg_v_d        = reg_v_q;
        acc_d          = acc_q;
        wdata_d        = wdata_q;
        rd_pend_d      = 1'b0;
        rd_idx_d       = rd_idx_q;
        finish         = 1'b0;
        out_valid_d    = 1'b0;
        mem_data_out_d = mem_data_out_q;
        reg_e_out_d    = reg_e_out_q;
        reg_v_out_d    = reg_v_out_q;
        wb_out_d       = wb_out_q;
        dest_out_d     = dest_out_q;
        dt_out_d       = dt_out_q;

        // Read data arrives one cycle after its address was issued.
        if (rd_pend_q) acc_d[int'(rd_idx_q)*ELEM_W +: ELEM_W] = mem_rdata;

        case (state_q)
            IDLE: begin
                if (gen_start) begin
                    state_d   = ISSUE;
                    is_load_d = (op == MEM_LOAD);
                    dt_d      = destType;
                    dest_d    = dest;
                    wb_d      = wb;
                    reg_e_d   = regE;
                    reg_v_d   = regV;
                    acc_d     = '0;
                    if (op == MEM_STORE) begin
                        wdata_d = destType ? regV[ELEM_W-1:0] : ELEM_W'(regE);
                    end
                end else if (accept) begin
                    out_valid_d    = 1'b1;
                    mem_data_out_d = '0;
                    reg_e_out_d    = regE;
                    reg_v_out_d    = regV;
                    wb_out_d       = wb;
                    dest_out_d     = dest;
                    dt_out_d       = destType;
                end
            end
            ISSUE: begin
                if (is_load_q) begin
                    rd_pend_d = 1'b1;
                    rd_idx_d  = k;
                end
                if (last) begin
                    if (is_load_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end
                end else if (!is_load_q) begin
                    wdata_d = reg_v_q[(int'(k)+1)*ELEM_W +: ELEM_W];
                end
            end
            DRAIN: begin
                state_d = IDLE;
                finish  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            out_valid_d    = 1'b1;
            mem_data_out_d = is_load_q ? acc_d : '0;
            reg_e_out_d    = reg_e_q;
            reg_v_out_d    = reg_v_q;
            wb_out_d       = wb_q;
            dest_out_d     = dest_q;
            dt_out_d       = dt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            is_load_q      <= 1'b0;
            dt_q           <= 1'b0;
            dest_q         <= '0;
            wb_q           <= '0;
            reg_e_q        <= '0;
            reg_v_q        <= '0;
            acc_q          <= '0;
            wdata_q        <= '0;
            rd_pend_q      <= 1'b0;
            rd_idx_q       <= '0;
            out_valid_q    <= 1'b0;
            mem_data_out_q <= '0;
            reg_e_out_q    <= '0;
            reg_v_out_q    <= '0;
            wb_out_q       <= '0;
            dest_out_q     <= '0;
            dt_out_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_load_q      <= is_load_d;
            dt_q           <= dt_d;
            dest_q         <= dest_d;
            wb_q           <= wb_d;
            reg_e_q        <= reg_e_d;
            reg_v_q        <= reg_v_d;
            acc_q          <= acc_d;
            wdata_q        <= wdata_d;
            rd_pend_q      <= rd_pend_d;
            rd_idx_q       <= rd_idx_d;
            out_valid_q    <= out_valid_d;
            mem_data_out_q <= mem_data_out_d;
            reg_e_out_q    <= reg_e_out_d;
            reg_v_out_q    <= reg_v_out_d;
            wb_out_q       <= wb_out_d;
            dest_out_q     <= dest_out_d;
            dt_out_q       <= dt_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign memData_o  = mem_data_out_q;
    assign regE_o     = reg_e_out_q;
    assign regV_o     = reg_v_out_q;
    assign wb_o       = wb_out_q;
    assign dest_o     = dest_out_q;
    assign destType_o = dt_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with a behavioural synchronous memory.
module tb_mem_access_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   memOp;
    logic         destType;
    logic [3:0]   dest;
    logic [1:0]   wb;
    logic [20:0]  regE;
    logic [191:0] regV;
    logic [20:0]  stride;
    logic [20:0]  mem_addr;
    logic         mem_we;
    logic [23:0]  mem_wdata;
    logic [23:0]  mem_rdata;
    logic         out_valid;
    logic [191:0] memData_o;
    logic [20:0]  regE_o;
    logic [191:0] regV_o;
    logic [1:0]   wb_o;
    logic [3:0]   dest_o;
    logic         destType_o;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .memOp      (memOp),
        .destType   (destType),
        .dest       (dest),
        .wb         (wb),
        .regE       (regE),
        .regV       (regV),
        .stride     (stride),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .memData_o  (memData_o),
        .regE_o     (regE_o),
        .regV_o     (regV_o),
        .wb_o       (wb_o),
        .dest_o     (dest_o),
        .destType_o (destType_o)
    );

    typedef struct {
        logic [20:0] addr;
        logic [23:0] data;
        int unsigned t;
    } wr_t;

    logic [23:0] mem [int unsigned];
    wr_t         wlog[$];
    int unsigned cyc = 0;

    // Synchronous memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= mem.exists(32'(mem_addr)) ? mem[32'(mem_addr)] : 24'h0;
        if (mem_we) begin
            wlog.push_back('{mem_addr, mem_wdata, cyc});
            mem[32'(mem_addr)] = mem_wdata;
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [1:0]   op;
        logic         dt;
        logic [3:0]   dest;
        logic [1:0]   wb;
        logic [20:0]  e;
        logic [191:0] v;
        logic [20:0]  s;
        int           lat;
        logic [191:0] md;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic dt, input logic [3:0] d,
                                input logic [1:0] w, input logic [20:0] e, input logic [191:0] v,
                                input logic [20:0] s, input int lat, input logic [191:0] md);
        vec_t r;
        r.op = op; r.dt = dt; r.dest = d; r.wb = w; r.e = e; r.v = v; r.s = s;
        r.lat = lat; r.md = md;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        memOp = v.op; destType = v.dt; dest = v.dest; wb = v.wb;
        regE = v.e; regV = v.v; stride = v.s;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        int acc_t;
        int n_exp;
        int step;
        logic [20:0] ea;
        logic [23:0] ed;
        @(negedge clk);
        wlog.delete();
        drive(v);
        in_valid = 1'b1;
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        acc_t    = int'(cyc) - 1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, v.lat);
        chk({nm, "_memData"}, memData_o, v.md);
        chk({nm, "_regE"}, regE_o, v.e);
        chk({nm, "_regV"}, regV_o, v.v);
        chk({nm, "_dest_wb_dt"}, {dest_o, wb_o, destType_o}, {v.dest, v.wb, v.dt});
        @(posedge clk);
        #1;
        chk({nm, "_strobe_one_cycle"}, out_valid, 1'b0);
`ifdef MEM_STRIDE_EN
        step = int'(v.s);
`else
        step = 1;
`endif
        n_exp = (v.op == 2'b10) ? (v.dt ? 8 : 1) : 0;
        chk({nm, "_write_count"}, wlog.size(), n_exp);
        for (int k = 0; k < n_exp && k < wlog.size(); k++) begin
            ea = v.e + 21'(k * step);
            ed = v.dt ? v.v[k*24 +: 24] : {3'b000, v.e};
            chk({nm, "_wr_addr"}, wlog[k].addr, ea);
            chk({nm, "_wr_data"}, wlog[k].data, ed);
            chk({nm, "_wr_cycle"}, wlog[k].t, acc_t + 1 + k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tv[9];
        logic [191:0] vec, wrap_md;
        int           lat;
        int           nvalid;

        for (int i = 0; i < 8; i++) vec[i*24 +: 24] = 24'(i + 1);
        mem[32'h1FFFFF] = 24'hABCDEF;
        mem[32'h1FFFFE] = 24'hA00001;
        for (int i = 0; i < 6; i++) mem[i] = 24'hB00000 + 24'(i);
        wrap_md[23:0]  = 24'hA00001;
        wrap_md[47:24] = 24'hABCDEF;
        for (int i = 0; i < 6; i++) wrap_md[(i+2)*24 +: 24] = 24'hB00000 + 24'(i);

        tv[0] = mk(2'b00, 1'b0, 4'd5, 2'b01, 21'h1ABCD,  192'hDEAD, 21'd1, 1,  '0);
        tv[1] = mk(2'b11, 1'b1, 4'd7, 2'b10, 21'h12345,  vec,       21'd1, 1,  '0);
        tv[2] = mk(2'b10, 1'b1, 4'd3, 2'b00, 21'h00100,  vec,       21'd1, 9,  '0);
        tv[3] = mk(2'b01, 1'b1, 4'd4, 2'b10, 21'h00100,  '0,        21'd1, 10, vec);
        tv[4] = mk(2'b01, 1'b0, 4'd1, 2'b11, 21'h1FFFFF, vec,       21'd1, 3,  192'hABCDEF);
        tv[5] = mk(2'b01, 1'b1, 4'd2, 2'b10, 21'h1FFFFE, '0,        21'd1, 10, wrap_md);
        tv[6] = mk(2'b10, 1'b0, 4'd6, 2'b00, 21'h00055,  vec,       21'd1, 2,  '0);
        tv[7] = mk(2'b01, 1'b0, 4'd8, 2'b10, 21'h00055,  '0,        21'd1, 3,  192'h55);
        tv[8] = mk(2'b10, 1'b1, 4'd9, 2'b01, 21'h00010,  vec,       21'd3, 9,  '0);

        rst = 1'b1; in_valid = 1'b0;
        drive(tv[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_outputs", {memData_o, regE_o, regV_o, wb_o, dest_o, destType_o}, '0);

        for (int i = 0; i < 9; i++) run_op(tv[i], $sformatf("vec%0d", i));

        // Busy ignore plus back-to-back acceptance in the out_valid cycle.
        @(negedge clk);
        wlog.delete();
        drive(mk(2'b10, 1'b1, 4'd3, 2'b00, 21'h00200, vec, 21'd1, 9, '0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(mk(2'b00, 1'b0, 4'd9, 2'b01, 21'h00777, 192'h1, 21'd1, 1, '0));
        chk("busy_in_ready", in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_store_latency", lat, 9);
        chk("b2b_store_dest", dest_o, 4'd3);
        chk("b2b_ready_in_valid_cycle", in_ready, 1'b1);
        chk("busy_no_extra_writes", wlog.size(), 8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_noop_valid", out_valid, 1'b1);
        chk("b2b_noop_pass", {dest_o, regE_o}, {4'd9, 21'h00777});

        // Reset in the middle of a vector load.
        @(negedge clk);
        drive(tv[3]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_outputs", {memData_o, dest_o}, '0);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) nvalid++;
        end
        chk("midrst_no_out_valid", nvalid, 0);
        run_op(tv[0], "post_reset_noop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
